// File: rtl/retire_trace_fifo.sv
// -----------------------------------------------------------------------------
// retire_trace_fifo
//
// Retirement monitor for the pipelined CPU. Every retiring instruction
// (branch/nop, register write, memory write, halt) gets a sequential
// instruction number and is queued in a FIFO. A consumer such as a testbench or
// a debug UART drains the queue over a valid/ready port. The block also keeps a
// free-running cycle counter, reports halt completion and runs a cycle watchdog.
//
// Optional feature macro: RETIRE_CYCLE_STAMP_EN
//   defined   - each entry also stores the cycle counter value at its push edge,
//               and out_cycle_o shows that stamp for the head entry.
//   undefined - no cycle field is stored and out_cycle_o is tied to 0.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active high
//   ret_valid_i    one instruction retires this cycle
//   ret_kind_i     0 = branch/nop, 1 = reg write, 2 = mem write, 3 = halt
//   ret_pc_i       pc of the retiring instruction
//   ret_reg_i      destination register (kind 1)
//   ret_data_i     write data (kind 1) or store data (kind 2)
//   ret_addr_i     memory address (kind 2, or kind 1 for a load)
//   out_valid_o    head entry valid
//   out_ready_i    consumer accepts the head entry
//   out_inum_o     instruction number of the head entry
//   out_kind_o, out_pc_o, out_reg_o, out_data_o, out_addr_o
//                  stored fields of the head entry
//   out_cycle_o    cycle stamp of the head entry (0 when stamping is disabled)
//   overflow_o     sticky: at least one entry was dropped
//   halted_o       sticky: halt accepted and the FIFO has drained
//   timeout_o      sticky: cycle counter reached MAX_CYCLES before halting
// -----------------------------------------------------------------------------
module retire_trace_fifo #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ret_valid_i,
    input  logic [1:0]        ret_kind_i,
    input  logic [DATA_W-1:0] ret_pc_i,
    input  logic [REG_W-1:0]  ret_reg_i,
    input  logic [DATA_W-1:0] ret_data_i,
    input  logic [DATA_W-1:0] ret_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  out_inum_o,
    output logic [1:0]        out_kind_o,
    output logic [DATA_W-1:0] out_pc_o,
    output logic [REG_W-1:0]  out_reg_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [DATA_W-1:0] out_addr_o,
    output logic [CNT_W-1:0]  out_cycle_o,
    output logic              overflow_o,
    output logic              halted_o,
    output logic              timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] KIND_HALT = 2'd3;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    // One stored FIFO entry. The cycle stamp only exists when the feature is
    // enabled so the memory stays as narrow as possible otherwise.
    typedef struct packed {
`ifdef RETIRE_CYCLE_STAMP_EN
        logic [CNT_W-1:0]  cycle;
`endif
        logic [CNT_W-1:0]  inum;
        logic [1:0]        kind;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] addr;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q,    wr_ptr_d;
    logic [AW:0]      rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] inum_cnt_q,  inum_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             halt_seen_q, halt_seen_d;
    logic             overflow_q,  overflow_d;
    logic             halted_q,    halted_d;
    logic             timeout_q,   timeout_d;

    // -------------------------------------------------------------------------
    // FIFO status and handshake decode
    // -------------------------------------------------------------------------
    logic   fifo_empty;
    logic   fifo_full;
    logic   accept;
    logic   pop;
    logic   push;
    logic   drop;
    entry_t wr_entry;
    entry_t head_entry;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop    = !fifo_empty && out_ready_i;
    assign accept = ret_valid_i && !halt_seen_q;
    // A pop in the same cycle frees the head slot, so a full FIFO can still push.
    assign push   = accept && (!fifo_full || pop);
    assign drop   = accept && fifo_full && !pop;

    always_comb begin
        wr_entry      = '0;
`ifdef RETIRE_CYCLE_STAMP_EN
        wr_entry.cycle = cycle_cnt_q;
`endif
        wr_entry.inum = inum_cnt_q;
        wr_entry.kind = ret_kind_i;
        wr_entry.pc   = ret_pc_i;
        wr_entry.rd   = ret_reg_i;
        wr_entry.data = ret_data_i;
        wr_entry.addr = ret_addr_i;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inum_cnt_d  = inum_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        halt_seen_d = halt_seen_q;
        overflow_d  = overflow_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Dropped entries still consume a number so the consumer sees a gap.
        if (accept) begin
            inum_cnt_d = inum_cnt_q + 1'b1;
            // A halt counts as seen even when its entry is dropped.
            if (ret_kind_i == KIND_HALT) begin
                halt_seen_d = 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end

        if (cycle_cnt_q != {CNT_W{1'b1}}) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end

        // Built from current-state values, so halted rises one edge after the
        // pop that emptied the FIFO.
        if (halt_seen_q && fifo_empty) begin
            halted_d = 1'b1;
        end

        // Compared against the counter's next value so the flag rises on the
        // same edge on which the counter reaches the limit.
        if ((cycle_cnt_d == MAX_CNT) && !halted_q) begin
            timeout_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inum_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            halt_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inum_cnt_q  <= inum_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_seen_q <= halt_seen_d;
            overflow_q  <= overflow_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage. No reset, so it maps onto RAM; the contents of unused
    // slots never reach the outputs because of the empty gating below.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // The head is read directly so a pushed entry is visible in the cycle right
    // after its push edge. It only changes when the read pointer moves, which
    // keeps out_* stable while the consumer stalls.
    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

    // -------------------------------------------------------------------------
    // Outputs: fields read as zero while the FIFO is empty.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_o = !fifo_empty;
        out_inum_o  = '0;
        out_kind_o  = '0;
        out_pc_o    = '0;
        out_reg_o   = '0;
        out_data_o  = '0;
        out_addr_o  = '0;
        out_cycle_o = '0;
        if (!fifo_empty) begin
            out_inum_o = head_entry.inum;
            out_kind_o = head_entry.kind;
            out_pc_o   = head_entry.pc;
            out_reg_o  = head_entry.rd;
            out_data_o = head_entry.data;
            out_addr_o = head_entry.addr;
`ifdef RETIRE_CYCLE_STAMP_EN
            out_cycle_o = head_entry.cycle;
`endif
        end
    end

    assign overflow_o = overflow_q;
    assign halted_o   = halted_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_fifo
//
// Directed and randomized stimulus for retire_trace_fifo. A queue-based
// reference model tracks the buffered entries, instruction numbering, cycle
// counter and the sticky flags; every cycle the DUT outputs are compared
// against it. Built with DEPTH=16 and MAX_CYCLES=50.
// -----------------------------------------------------------------------------
module tb_retire_trace_fifo;

    localparam int DATA_W     = 16;
    localparam int REG_W      = 4;
    localparam int DEPTH      = 16;
    localparam int CNT_W      = 32;
    localparam int MAX_CYCLES = 50;

    logic              clk;
    logic              rst;
    logic              ret_valid_i;
    logic [1:0]        ret_kind_i;
    logic [DATA_W-1:0] ret_pc_i;
    logic [REG_W-1:0]  ret_reg_i;
    logic [DATA_W-1:0] ret_data_i;
    logic [DATA_W-1:0] ret_addr_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CNT_W-1:0]  out_inum_o;
    logic [1:0]        out_kind_o;
    logic [DATA_W-1:0] out_pc_o;
    logic [REG_W-1:0]  out_reg_o;
    logic [DATA_W-1:0] out_data_o;
    logic [DATA_W-1:0] out_addr_o;
    logic [CNT_W-1:0]  out_cycle_o;
    logic              overflow_o;
    logic              halted_o;
    logic              timeout_o;

    retire_trace_fifo #(
        .DATA_W     (DATA_W),
        .REG_W      (REG_W),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ret_valid_i (ret_valid_i),
        .ret_kind_i  (ret_kind_i),
        .ret_pc_i    (ret_pc_i),
        .ret_reg_i   (ret_reg_i),
        .ret_data_i  (ret_data_i),
        .ret_addr_i  (ret_addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_inum_o  (out_inum_o),
        .out_kind_o  (out_kind_o),
        .out_pc_o    (out_pc_o),
        .out_reg_o   (out_reg_o),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_cycle_o (out_cycle_o),
        .overflow_o  (overflow_o),
        .halted_o    (halted_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        bit [31:0] inum;
        bit [1:0]  kind;
        bit [15:0] pc;
        bit [3:0]  rg;
        bit [15:0] data;
        bit [15:0] addr;
        bit [31:0] cyc;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] m_inum;
    bit [31:0] m_cyc;
    bit        m_halt_seen;
    bit        m_halted;
    bit        m_timeout;
    bit        m_overflow;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] exp_stamp(input bit [31:0] c);
`ifdef RETIRE_CYCLE_STAMP_EN
        return c;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid_o, 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_inum",  out_inum_o,  mq[0].inum);
            chk("out_kind",  out_kind_o,  mq[0].kind);
            chk("out_pc",    out_pc_o,    mq[0].pc);
            chk("out_reg",   out_reg_o,   mq[0].rg);
            chk("out_data",  out_data_o,  mq[0].data);
            chk("out_addr",  out_addr_o,  mq[0].addr);
            chk("out_cycle", out_cycle_o, exp_stamp(mq[0].cyc));
        end
        chk("overflow", overflow_o, m_overflow);
        chk("halted",   halted_o,   m_halted);
        chk("timeout",  timeout_o,  m_timeout);
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, check.
    task automatic step(input bit v, input bit [1:0] k, input bit [15:0] pc,
                        input bit [3:0] r, input bit [15:0] d, input bit [15:0] a,
                        input bit rdy);
        bit   do_pop, acc, full, old_hs, old_empty, old_halted;
        ent_t e;
        ret_valid_i = v;
        ret_kind_i  = k;
        ret_pc_i    = pc;
        ret_reg_i   = r;
        ret_data_i  = d;
        ret_addr_i  = a;
        out_ready_i = rdy;
        do_pop     = (mq.size() != 0) && rdy;
        acc        = v && !m_halt_seen;
        full       = (mq.size() == DEPTH);
        old_hs     = m_halt_seen;
        old_empty  = (mq.size() == 0);
        old_halted = m_halted;
        @(posedge clk);
        if (do_pop) begin
            e = mq.pop_front();
            $display("pop  inum=%0d kind=%0d pc=%h reg=%0d data=%h addr=%h cyc=%0d",
                     e.inum, e.kind, e.pc, e.rg, e.data, e.addr, e.cyc);
        end
        if (acc) begin
            if (!full || do_pop) begin
                e.inum = m_inum; e.kind = k; e.pc = pc; e.rg = r;
                e.data = d; e.addr = a; e.cyc = m_cyc;
                mq.push_back(e);
            end else begin
                m_overflow = 1'b1;
            end
            if (k == 2'd3) m_halt_seen = 1'b1;
            m_inum++;
        end
        if (old_hs && old_empty) m_halted = 1'b1;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if ((m_cyc == MAX_CYCLES) && !old_halted) m_timeout = 1'b1;
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 2'd0, 16'h0, 4'h0, 16'h0, 16'h0, rdy);
    endtask

    task automatic rand_ret(input bit rdy);
        step(1'b1, 2'($urandom_range(0, 2)), 16'($urandom), 4'($urandom),
             16'($urandom), 16'($urandom), rdy);
    endtask

    task automatic do_reset();
        ret_valid_i = 1'b0;
        out_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        mq.delete();
        m_inum = 0; m_cyc = 0;
        m_halt_seen = 0; m_halted = 0; m_timeout = 0; m_overflow = 0;
        chk("rst_valid",    out_valid_o, 0);
        chk("rst_overflow", overflow_o,  0);
        chk("rst_timeout",  timeout_o,   0);
        chk("rst_halted",   halted_o,    0);
        chk("rst_inum",     out_inum_o,  0);
        chk("rst_cycle",    out_cycle_o, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid_o, 0);
        chk("rst_hold_pc",    out_pc_o,    0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ret_valid_i = 0; ret_kind_i = 0; ret_pc_i = 0; ret_reg_i = 0;
        ret_data_i = 0; ret_addr_i = 0; out_ready_i = 0;
        @(posedge clk);
        #1;

        // 1: reset, then first retire appears next cycle with inum 0
        do_reset();
        step(1'b1, 2'd1, 16'h0000, 4'd3, 16'h0005, 16'h0000, 1'b0);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_inum",  out_inum_o,  0);
        chk("t1_data",  out_data_o,  16'h0005);

        // 2: 20 retires into a 16-deep FIFO, drain, then the next inum is 20
        do_reset();
        for (int i = 0; i < 20; i++) rand_ret(1'b0);
        chk("t2_overflow", overflow_o, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_inum", out_inum_o, i);
            idle(1'b1);
        end
        chk("t2_empty", out_valid_o, 0);
        rand_ret(1'b0);
        chk("t2_next_inum", out_inum_o, 20);

        // 3: full FIFO with simultaneous push and pop never drops
        do_reset();
        for (int i = 0; i < 16; i++) rand_ret(1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t3_head_inum", out_inum_o, i);
            rand_ret(1'b1);
        end
        chk("t3_overflow", overflow_o, 0);
        chk("t3_head_after", out_inum_o, 8);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 7) rand_ret(1'($urandom_range(0, 1)));
            else                          idle(1'($urandom_range(0, 1)));
        end

        // 6: cycle stamps at cycles 7 and 9
        do_reset();
        for (int i = 0; i < 20 && m_cyc != 7; i++) idle(1'b0);
        step(1'b1, 2'd2, 16'h0100, 4'd0, 16'hBEEF, 16'h0040, 1'b0);
        idle(1'b0);
        step(1'b1, 2'd1, 16'h0102, 4'd7, 16'h1234, 16'h0000, 1'b0);
        chk("t6_first_stamp", out_cycle_o, exp_stamp(32'd7));
        idle(1'b1);
        chk("t6_second_stamp", out_cycle_o, exp_stamp(32'd9));

        // 5: watchdog fires at cycle 50 without a halt; reset mid-run clears all
        for (int i = 0; i < 60 && m_cyc != MAX_CYCLES - 1; i++) idle(1'b1);
        chk("t5_before", timeout_o, 0);
        idle(1'b1);
        chk("t5_timeout", timeout_o, 1);
        for (int i = 0; i < 5; i++) rand_ret(1'b0);
        chk("t5_queued", out_valid_o, 1);
        do_reset();
        idle(1'b0);
        chk("t5_cleared_timeout", timeout_o, 0);
        chk("t5_cleared_valid", out_valid_o, 0);

        // 4: halt behind 3 queued entries, later retires ignored
        do_reset();
        for (int i = 0; i < 3; i++) rand_ret(1'b0);
        step(1'b1, 2'd3, 16'h0010, 4'd0, 16'h0, 16'h0, 1'b0);
        rand_ret(1'b0);
        rand_ret(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_inum", out_inum_o, i);
            idle(1'b1);
        end
        chk("t4_not_yet", halted_o, 0);
        idle(1'b1);
        chk("t4_halted", halted_o, 1);
        rand_ret(1'b1);
        chk("t4_ignored", out_valid_o, 0);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
